// File: rtl/mc_control_unit_if.sv
// Decode/strobe bundle between the multi-cycle control unit (master) and the datapath (slave).
interface mc_control_unit_if #(
  parameter int unsigned OPW = 6
);
  logic [OPW-1:0] decode;
  logic           zero;
  logic           RegWre;
  logic           PCWre;
  logic           IRWre;
  logic           InsMemRW;
  logic           ALUSrcB;
  logic           ExtSel;
  logic [2:0]     ALUOp;
  logic           ALUM2Reg;
  logic           DataMemRw;
  logic [1:0]     RegOut;
  logic           WrRegData;
  logic [1:0]     PCSrc;
  logic [2:0]     state;

  modport master (
    input  decode, zero,
    output RegWre, PCWre, IRWre, InsMemRW, ALUSrcB, ExtSel, ALUOp,
           ALUM2Reg, DataMemRw, RegOut, WrRegData, PCSrc, state
  );

  modport slave (
    output decode, zero,
    input  RegWre, PCWre, IRWre, InsMemRW, ALUSrcB, ExtSel, ALUOp,
           ALUM2Reg, DataMemRw, RegOut, WrRegData, PCSrc, state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM sequencing IF/ID/EXE/MEM/WB from the IR opcode and ALU zero.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: unlisted opcodes park in HALT instead of acting as NOP.
module mc_control_unit #(
  parameter int unsigned    OPW         = 6,
  parameter logic [OPW-1:0] HALT_OPCODE = OPW'(6'b111111)
) (
  input logic              clk,
  input logic              reset,
  mc_control_unit_if.master bus
);

  localparam int unsigned ALUOPW = 3;
  localparam int unsigned SELW   = 2;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6'b010000);
  localparam logic [OPW-1:0] OP_AND  = OPW'(6'b010001);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b010010);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6'b011000);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(6'b100110);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b110000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b110001);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b110100);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b111000);
  localparam logic [OPW-1:0] OP_JR   = OPW'(6'b111001);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(6'b111010);

  localparam logic [ALUOPW-1:0] ALU_ADD = ALUOPW'(3'b000);
  localparam logic [ALUOPW-1:0] ALU_SUB = ALUOPW'(3'b001);
  localparam logic [ALUOPW-1:0] ALU_OR  = ALUOPW'(3'b010);
  localparam logic [ALUOPW-1:0] ALU_AND = ALUOPW'(3'b011);
  localparam logic [ALUOPW-1:0] ALU_SLL = ALUOPW'(3'b100);
  localparam logic [ALUOPW-1:0] ALU_SLT = ALUOPW'(3'b101);

  localparam logic [SELW-1:0] PC_SEQ  = SELW'(2'b00);
  localparam logic [SELW-1:0] PC_BR   = SELW'(2'b01);
  localparam logic [SELW-1:0] PC_RS   = SELW'(2'b10);
  localparam logic [SELW-1:0] PC_JMP  = SELW'(2'b11);
  localparam logic [SELW-1:0] RD_R31  = SELW'(2'b00);
  localparam logic [SELW-1:0] RD_RT   = SELW'(2'b01);
  localparam logic [SELW-1:0] RD_RD   = SELW'(2'b10);

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b111
  } state_e;

  state_e state_q, state_d;

  logic              is_rtype, is_imm, is_sext, is_alu, is_lw, is_sw, is_beq;
  logic              is_jump, is_legal;
  logic [ALUOPW-1:0] op_alu;

  logic              reg_wre, pc_wre, ir_wre, ins_mem_rw, alu_src_b, ext_sel;
  logic              alu_m2reg, data_mem_rw, wr_reg_data;
  logic [ALUOPW-1:0] alu_op;
  logic [SELW-1:0]   reg_out, pc_src;

  // Opcode classification; only consulted once the IR is stable (ID onward).
  always_comb begin
    is_rtype = 1'b0;
    is_imm   = 1'b0;
    is_sext  = 1'b0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    is_beq   = 1'b0;
    is_jump  = 1'b0;
    op_alu   = ALU_ADD;
    case (decode_w())
      OP_ADD:  is_rtype = 1'b1;
      OP_SUB:  begin is_rtype = 1'b1; op_alu = ALU_SUB; end
      OP_OR:   begin is_rtype = 1'b1; op_alu = ALU_OR;  end
      OP_AND:  begin is_rtype = 1'b1; op_alu = ALU_AND; end
      OP_SLL:  begin is_rtype = 1'b1; op_alu = ALU_SLL; end
      OP_SLT:  begin is_rtype = 1'b1; op_alu = ALU_SLT; end
      OP_ADDI: begin is_imm = 1'b1; is_sext = 1'b1; end
      OP_ORI:  begin is_imm = 1'b1; op_alu = ALU_OR; end
      OP_LW:   begin is_imm = 1'b1; is_sext = 1'b1; is_lw = 1'b1; end
      OP_SW:   begin is_imm = 1'b1; is_sext = 1'b1; is_sw = 1'b1; end
      OP_BEQ:  begin is_sext = 1'b1; is_beq = 1'b1; op_alu = ALU_SUB; end
      OP_J, OP_JR, OP_JAL: is_jump = 1'b1;
      default: ;
    endcase
    is_alu   = is_rtype | (is_imm & ~is_lw & ~is_sw);
    is_legal = is_alu | is_lw | is_sw | is_beq | is_jump;
  end

  function automatic logic [OPW-1:0] decode_w();
    return bus.decode;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next state and strobes; everything held low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    reg_wre     = 1'b0;
    pc_wre      = 1'b0;
    ir_wre      = 1'b0;
    ins_mem_rw  = 1'b0;
    alu_src_b   = 1'b0;
    ext_sel     = 1'b0;
    alu_op      = ALU_ADD;
    alu_m2reg   = 1'b0;
    data_mem_rw = 1'b0;
    reg_out     = RD_R31;
    wr_reg_data = 1'b0;
    pc_src      = PC_SEQ;
    if (reset) begin
      case (state_q)
        S_IF: begin
          ir_wre     = 1'b1;
          ins_mem_rw = 1'b1;
          state_d    = S_ID;
        end
        S_ID: begin
          if (bus.decode == HALT_OPCODE) begin
            state_d = S_HALT;
          end else if (is_jump) begin
            pc_wre  = 1'b1;
            pc_src  = (bus.decode == OP_JR) ? PC_RS : PC_JMP;
            reg_wre = (bus.decode == OP_JAL);
            state_d = S_IF;
          end else if (is_legal) begin
            state_d = S_EXE;
          end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            pc_wre  = 1'b1;
            pc_src  = PC_SEQ;
            state_d = S_IF;
`endif
          end
        end
        S_EXE: begin
          alu_op    = op_alu;
          alu_src_b = is_imm;
          ext_sel   = is_sext;
          if (is_beq) begin
            pc_wre  = 1'b1;
            pc_src  = bus.zero ? PC_BR : PC_SEQ;
            state_d = S_IF;
          end else if (is_lw || is_sw) begin
            state_d = S_MEM;
          end else if (is_alu) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
          end
        end
        S_MEM: begin
          if (is_lw) begin
            alu_m2reg = 1'b1;
            state_d   = S_WB;
          end else begin
            data_mem_rw = is_sw;
            pc_wre      = 1'b1;
            state_d     = S_IF;
          end
        end
        S_WB: begin
          reg_wre     = 1'b1;
          wr_reg_data = 1'b1;
          pc_wre      = 1'b1;
          reg_out     = is_rtype ? RD_RD : RD_RT;
          state_d     = S_IF;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_IF;
      endcase
    end
  end

  assign bus.RegWre    = reg_wre;
  assign bus.PCWre     = pc_wre;
  assign bus.IRWre     = ir_wre;
  assign bus.InsMemRW  = ins_mem_rw;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ExtSel    = ext_sel;
  assign bus.ALUOp     = alu_op;
  assign bus.ALUM2Reg  = alu_m2reg;
  assign bus.DataMemRw = data_mem_rw;
  assign bus.RegOut    = reg_out;
  assign bus.WrRegData = wr_reg_data;
  assign bus.PCSrc     = pc_src;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class state by state.
module tb_mc_control_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  mc_control_unit_if #(.OPW(6)) bus ();
  mc_control_unit #(.OPW(6), .HALT_OPCODE(6'b111111)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // {RegWre,PCWre,IRWre,InsMemRW,ALUSrcB,ExtSel,ALUOp,ALUM2Reg,DataMemRw,RegOut,WrRegData,PCSrc,state}
  logic [18:0] obs;
  assign obs = {bus.RegWre, bus.PCWre, bus.IRWre, bus.InsMemRW, bus.ALUSrcB, bus.ExtSel,
                bus.ALUOp, bus.ALUM2Reg, bus.DataMemRw, bus.RegOut, bus.WrRegData,
                bus.PCSrc, bus.state};

  function automatic logic [18:0] pk(input logic rw, pw, irw, imr, asb, ext,
                                     input logic [2:0] aop, input logic m2r, dmw,
                                     input logic [1:0] ro, input logic wrd,
                                     input logic [1:0] pcs, input logic [2:0] st);
    return {rw, pw, irw, imr, asb, ext, aop, m2r, dmw, ro, wrd, pcs, st};
  endfunction

  logic [18:0] v_if, v_id, v_zero, v_halt;

  task automatic test_reset();
    reset = 1'b0;
    bus.decode = 6'b000000;
    bus.zero = 1'b0;
    #2;
    checks++;
    if (obs !== v_zero) begin
      failures++;
      $display("FAIL reset_held obs=%h exp=%h", obs, v_zero);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== v_if) begin
      failures++;
      $display("FAIL reset_release obs=%h exp=%h", obs, v_if);
    end
  endtask

  // R-type and immediate ALU ops: IF, ID, EXE, WB, IF.
  task automatic test_alu();
    logic [5:0] ops  [4] = '{6'b000000, 6'b010010, 6'b000010, 6'b100110};
    logic [2:0] aops [4] = '{3'b000, 3'b010, 3'b000, 3'b101};
    logic       asbs [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       exts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0] ros  [4] = '{2'b10, 2'b01, 2'b01, 2'b10};
    logic [18:0] exp [5];
    for (int k = 0; k < 4; k++) begin
      bus.decode = ops[k];
      exp[0] = v_if;
      exp[1] = v_id;
      exp[2] = pk(0,0,0,0,asbs[k],exts[k],aops[k],0,0,2'd0,0,2'd0,3'd2);
      exp[3] = pk(1,1,0,0,0,0,3'd0,0,0,ros[k],1,2'd0,3'd4);
      exp[4] = v_if;
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (obs !== exp[i]) begin
          failures++;
          $display("FAIL alu op=%b step%0d obs=%h exp=%h", ops[k], i, obs, exp[i]);
        end
        if (i < 4) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic test_lw();
    logic [18:0] exp [6];
    bus.decode = 6'b110001;
    exp[0] = v_if;
    exp[1] = v_id;
    exp[2] = pk(0,0,0,0,1,1,3'd0,0,0,2'd0,0,2'd0,3'd2);
    exp[3] = pk(0,0,0,0,0,0,3'd0,1,0,2'd0,0,2'd0,3'd3);
    exp[4] = pk(1,1,0,0,0,0,3'd0,0,0,2'd1,1,2'd0,3'd4);
    exp[5] = v_if;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL lw step%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_sw();
    logic [18:0] exp [5];
    bus.decode = 6'b110000;
    exp[0] = v_if;
    exp[1] = v_id;
    exp[2] = pk(0,0,0,0,1,1,3'd0,0,0,2'd0,0,2'd0,3'd2);
    exp[3] = pk(0,1,0,0,0,0,3'd0,0,1,2'd0,0,2'd0,3'd3);
    exp[4] = v_if;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL sw step%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_beq();
    logic [18:0] exp [4];
    for (int z = 1; z >= 0; z--) begin
      bus.decode = 6'b110100;
      bus.zero = 1'(z);
      exp[0] = v_if;
      exp[1] = v_id;
      exp[2] = pk(0,1,0,0,0,1,3'b001,0,0,2'd0,0,(z == 1) ? 2'b01 : 2'b00,3'd2);
      exp[3] = v_if;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs !== exp[i]) begin
          failures++;
          $display("FAIL beq zero=%0d step%0d obs=%h exp=%h", z, i, obs, exp[i]);
        end
        if (i < 3) begin @(posedge clk); #1; end
      end
    end
    bus.zero = 1'b0;
  endtask

  task automatic test_jump();
    logic [5:0]  ops [3] = '{6'b111010, 6'b111000, 6'b111001};
    logic [18:0] ids [3];
    ids[0] = pk(1,1,0,0,0,0,3'd0,0,0,2'b00,0,2'b11,3'd1);
    ids[1] = pk(0,1,0,0,0,0,3'd0,0,0,2'b00,0,2'b11,3'd1);
    ids[2] = pk(0,1,0,0,0,0,3'd0,0,0,2'b00,0,2'b10,3'd1);
    for (int k = 0; k < 3; k++) begin
      bus.decode = ops[k];
      @(posedge clk); #1;
      checks++;
      if (obs !== ids[k]) begin
        failures++;
        $display("FAIL jump op=%b id obs=%h exp=%h", ops[k], obs, ids[k]);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== v_if) begin
        failures++;
        $display("FAIL jump op=%b return obs=%h exp=%h", ops[k], obs, v_if);
      end
    end
  endtask

  // j immediately followed by sub, decode swapped while in IF.
  task automatic test_back_to_back();
    logic [18:0] exp [7];
    logic [5:0]  dec [7] = '{6'b111000, 6'b111000, 6'b000001, 6'b000001,
                             6'b000001, 6'b000001, 6'b000001};
    exp[0] = v_if;
    exp[1] = pk(0,1,0,0,0,0,3'd0,0,0,2'd0,0,2'b11,3'd1);
    exp[2] = v_if;
    exp[3] = v_id;
    exp[4] = pk(0,0,0,0,0,0,3'b001,0,0,2'd0,0,2'd0,3'd2);
    exp[5] = pk(1,1,0,0,0,0,3'd0,0,0,2'b10,1,2'd0,3'd4);
    exp[6] = v_if;
    for (int i = 0; i < 7; i++) begin
      bus.decode = dec[i];
      #1;
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL b2b step%0d obs=%h exp=%h", i, obs, exp[i]);
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_async_reset();
    bus.decode = 6'b000000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (obs !== pk(0,0,0,0,0,0,3'd0,0,0,2'd0,0,2'd0,3'd2)) begin
      failures++;
      $display("FAIL arst_pre obs=%h exp state=2", obs);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== v_zero) begin
      failures++;
      $display("FAIL arst_assert obs=%h exp=%h", obs, v_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== v_zero) begin
      failures++;
      $display("FAIL arst_hold obs=%h exp=%h", obs, v_zero);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== v_if) begin
      failures++;
      $display("FAIL arst_release obs=%h exp=%h", obs, v_if);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== v_id) begin
      failures++;
      $display("FAIL arst_next obs=%h exp=%h", obs, v_id);
    end
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    checks++;
    if (obs !== v_if) begin
      failures++;
      $display("FAIL arst_complete obs=%h exp=%h", obs, v_if);
    end
  endtask

  task automatic test_halt();
    bus.decode = 6'b111111;
    @(posedge clk); #1;
    checks++;
    if (obs !== v_id) begin
      failures++;
      $display("FAIL halt_id obs=%h exp=%h", obs, v_id);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== v_halt) begin
        failures++;
        $display("FAIL halt_hold cyc%0d obs=%h exp=%h", i, obs, v_halt);
      end
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== v_if) begin
      failures++;
      $display("FAIL halt_exit obs=%h exp=%h", obs, v_if);
    end
  endtask

  task automatic test_illegal();
    logic [18:0] exp_id, exp_next;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    exp_id   = v_id;
    exp_next = v_halt;
`else
    exp_id   = pk(0,1,0,0,0,0,3'd0,0,0,2'd0,0,2'b00,3'd1);
    exp_next = v_if;
`endif
    bus.decode = 6'b101010;
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_id) begin
      failures++;
      $display("FAIL illegal_id obs=%h exp=%h", obs, exp_id);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== exp_next) begin
      failures++;
      $display("FAIL illegal_next obs=%h exp=%h", obs, exp_next);
    end
    reset = 1'b0;
    #2 reset = 1'b1;
    #1;
  endtask

  initial begin
    v_if   = pk(0,0,1,1,0,0,3'd0,0,0,2'd0,0,2'd0,3'd0);
    v_id   = pk(0,0,0,0,0,0,3'd0,0,0,2'd0,0,2'd0,3'd1);
    v_zero = pk(0,0,0,0,0,0,3'd0,0,0,2'd0,0,2'd0,3'd0);
    v_halt = pk(0,0,0,0,0,0,3'd0,0,0,2'd0,0,2'd0,3'd7);
    test_reset();
    test_alu();
    test_lw();
    test_sw();
    test_beq();
    test_jump();
    test_back_to_back();
    test_async_reset();
    test_halt();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
